// File: rtl/sap_pkg.sv
// Shared definitions for the 8-bit SAP-style CPU: opcodes, control-word bit
// positions and default datapath widths.
package sap_pkg;

    localparam int DEF_ADDR_W   = 4;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_OPCODE_W = 4;

    localparam logic [DEF_OPCODE_W-1:0] OP_HLT = 4'h0;
    localparam logic [DEF_OPCODE_W-1:0] OP_LDA = 4'h1;
    localparam logic [DEF_OPCODE_W-1:0] OP_ADD = 4'h2;
    localparam logic [DEF_OPCODE_W-1:0] OP_SUB = 4'h3;
    localparam logic [DEF_OPCODE_W-1:0] OP_OUT = 4'h4;
    localparam logic [DEF_OPCODE_W-1:0] OP_JMP = 4'h5;

    // Bit positions in the sequencer's control word
    localparam int SIG_PC_INC     = 0;
    localparam int SIG_PC_EN      = 1;
    localparam int SIG_PC_LOAD    = 2;
    localparam int SIG_MAR_LOAD_N = 3;
    localparam int SIG_RAM_EN_N   = 4;
    localparam int SIG_IR_LOAD_N  = 5;
    localparam int SIG_IR_EN_N    = 6;
    localparam int SIG_A_LOAD_N   = 7;
    localparam int SIG_A_EN       = 8;
    localparam int SIG_ALU_SUB    = 9;
    localparam int SIG_ALU_EN     = 10;
    localparam int SIG_B_LOAD_N   = 11;
    localparam int SIG_OUT_LOAD_N = 12;

endpackage

// File: rtl/fetch_unit_if.sv
// Control inputs, shared-bus connection and status outputs of the fetch unit.
interface fetch_unit_if
    import sap_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int OPCODE_W = DEF_OPCODE_W
);
    logic                pc_inc;
    logic                pc_en;
    logic                pc_load;
    logic                ir_load_n;
    logic                ir_en_n;
    logic                halt;
    logic [DATA_W-1:0]   bus_in;
    logic [DATA_W-1:0]   bus_out;
    logic                bus_oe;
    logic [OPCODE_W-1:0] opcode;
    logic [ADDR_W-1:0]   pc_value;
    logic                ir_valid;
    logic                bus_conflict;

    modport master (
        output pc_inc, pc_en, pc_load, ir_load_n, ir_en_n, halt, bus_in,
        input  bus_out, bus_oe, opcode, pc_value, ir_valid, bus_conflict
    );

    modport slave (
        input  pc_inc, pc_en, pc_load, ir_load_n, ir_en_n, halt, bus_in,
        output bus_out, bus_oe, opcode, pc_value, ir_valid, bus_conflict
    );
endinterface

// File: rtl/fetch_pc_counter.sv
// Program counter: hold > load > increment, wrapping modulo 2**ADDR_W.
module fetch_pc_counter
    import sap_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold_i,
    input  logic              load_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] load_val_i,
    output logic [ADDR_W-1:0] pc_o
);
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (hold_i)
            pc_d = pc_q;
        else if (load_i)
            pc_d = load_val_i;
        else if (inc_i)
            pc_d = pc_q + ADDR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc_q <= '0;
        else
            pc_q <= pc_d;
    end

    assign pc_o = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// PC plus instruction register for the 8-bit CPU; supplies the opcode to the
// sequencer and drives the PC or IR operand onto the shared bus.
module fetch_unit
    import sap_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int OPCODE_W = DEF_OPCODE_W
) (
    input  logic        clk,
    input  logic        rst_n,
    fetch_unit_if.slave bus_if
);
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir_q,       ir_d;
    logic              ir_valid_q, ir_valid_d;
    logic              conflict_q, conflict_d;

    fetch_pc_counter #(.ADDR_W(ADDR_W)) u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold_i     (bus_if.halt),
        .load_i     (bus_if.pc_load),
        .inc_i      (bus_if.pc_inc),
        .load_val_i (bus_if.bus_in[ADDR_W-1:0]),
        .pc_o       (pc)
    );

    always_comb begin
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        conflict_d = conflict_q;
        if (!bus_if.ir_load_n && !bus_if.halt) begin
            ir_d       = bus_if.bus_in;
            ir_valid_d = 1'b1;
        end
        // Sticky until reset; still watched while halted
        if (bus_if.pc_en && !bus_if.ir_en_n)
            conflict_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            conflict_q <= conflict_d;
        end
    end

    // Bus mux depends only on control inputs and state, never on bus_in
    always_comb begin
        bus_if.bus_out = '0;
        bus_if.bus_oe  = 1'b0;
        if (rst_n) begin
            if (bus_if.pc_en) begin
                bus_if.bus_out = {{OPCODE_W{1'b0}}, pc};
                bus_if.bus_oe  = 1'b1;
            end else if (!bus_if.ir_en_n) begin
                bus_if.bus_out = {{OPCODE_W{1'b0}}, ir_q[ADDR_W-1:0]};
                bus_if.bus_oe  = 1'b1;
            end
        end
    end

    assign bus_if.opcode       = ir_q[DATA_W-1:ADDR_W];
    assign bus_if.pc_value     = pc;
    assign bus_if.ir_valid     = ir_valid_q;
    assign bus_if.bus_conflict = conflict_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table plus hand-written reset sequences.
module tb_fetch_unit;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    fetch_unit_if u_if ();

    fetch_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       pc_inc, pc_en, pc_load, ir_load_n, ir_en_n, halt;
        logic [7:0] bus_in;
        logic [7:0] exp_bus;
        logic       exp_oe;
        logic [3:0] exp_pc, exp_op;
        logic       exp_valid, exp_conf;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic inc, en, ld, irl_n, ire_n, hlt,
                                input logic [7:0] bin, input logic [7:0] eb,
                                input logic eoe, input logic [3:0] epc, eop,
                                input logic ev, ec);
        vec_t v;
        v.pc_inc = inc; v.pc_en = en; v.pc_load = ld;
        v.ir_load_n = irl_n; v.ir_en_n = ire_n; v.halt = hlt;
        v.bus_in = bin; v.exp_bus = eb; v.exp_oe = eoe;
        v.exp_pc = epc; v.exp_op = eop; v.exp_valid = ev; v.exp_conf = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic inc, en, ld, irl_n, ire_n, hlt, input logic [7:0] bin);
        u_if.pc_inc = inc; u_if.pc_en = en; u_if.pc_load = ld;
        u_if.ir_load_n = irl_n; u_if.ir_en_n = ire_n; u_if.halt = hlt;
        u_if.bus_in = bin;
    endtask

    task automatic check_state(input string tag, input logic [3:0] pc, op,
                               input logic v, c);
        check({tag, " pc_value"},     {4'h0, u_if.pc_value},     {4'h0, pc});
        check({tag, " opcode"},       {4'h0, u_if.opcode},       {4'h0, op});
        check({tag, " ir_valid"},     {7'h0, u_if.ir_valid},     {7'h0, v});
        check({tag, " bus_conflict"}, {7'h0, u_if.bus_conflict}, {7'h0, c});
    endtask

    initial begin
        //            inc en ld irl ire hlt bus_in   exp_bus oe  pc    op    v  c
        vecs[0]  = mk(1, 0, 1, 1, 1, 0, 8'h37, 8'h00, 0, 4'h7, 4'h0, 0, 0);
        vecs[1]  = mk(0, 1, 0, 0, 1, 0, 8'h2A, 8'h07, 1, 4'h7, 4'h2, 1, 0);
        vecs[2]  = mk(0, 0, 0, 1, 0, 0, 8'h00, 8'h0A, 1, 4'h7, 4'h2, 1, 0);
        vecs[3]  = mk(0, 0, 1, 1, 1, 0, 8'hFE, 8'h00, 0, 4'hE, 4'h2, 1, 0);
        vecs[4]  = mk(1, 0, 0, 1, 1, 0, 8'h00, 8'h00, 0, 4'hF, 4'h2, 1, 0);
        vecs[5]  = mk(1, 0, 0, 1, 1, 0, 8'h00, 8'h00, 0, 4'h0, 4'h2, 1, 0);
        vecs[6]  = mk(1, 1, 0, 1, 1, 0, 8'h00, 8'h00, 1, 4'h1, 4'h2, 1, 0);
        vecs[7]  = mk(1, 1, 0, 0, 1, 1, 8'h55, 8'h01, 1, 4'h1, 4'h2, 1, 0);
        vecs[8]  = mk(1, 1, 0, 0, 1, 1, 8'h55, 8'h01, 1, 4'h1, 4'h2, 1, 0);
        vecs[9]  = mk(1, 1, 0, 0, 1, 1, 8'h55, 8'h01, 1, 4'h1, 4'h2, 1, 0);
        vecs[10] = mk(0, 0, 1, 1, 0, 1, 8'h09, 8'h0A, 1, 4'h1, 4'h2, 1, 0);
        vecs[11] = mk(0, 0, 0, 0, 1, 0, 8'hC3, 8'h00, 0, 4'h1, 4'hC, 1, 0);
        vecs[12] = mk(0, 0, 0, 1, 0, 0, 8'h00, 8'h03, 1, 4'h1, 4'hC, 1, 0);
        vecs[13] = mk(0, 1, 0, 1, 0, 0, 8'h00, 8'h01, 1, 4'h1, 4'hC, 1, 1);
        vecs[14] = mk(0, 0, 0, 1, 1, 0, 8'h00, 8'h00, 0, 4'h1, 4'hC, 1, 1);
        vecs[15] = mk(0, 1, 0, 1, 0, 1, 8'h00, 8'h01, 1, 4'h1, 4'hC, 1, 1);
        vecs[16] = mk(0, 0, 1, 0, 1, 0, 8'h5B, 8'h00, 0, 4'hB, 4'h5, 1, 1);

        rst_n = 1'b0;
        drive(1, 1, 0, 0, 0, 0, 8'hFF);
        #2;
        check("reset bus_oe",  {7'h0, u_if.bus_oe}, 8'h00);
        check("reset bus_out", u_if.bus_out, 8'h00);
        check_state("reset", 4'h0, 4'h0, 1'b0, 1'b0);
        drive(0, 0, 0, 1, 1, 0, 8'h00);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        check_state("post-reset idle", 4'h0, 4'h0, 1'b0, 1'b0);

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].pc_inc, vecs[i].pc_en, vecs[i].pc_load,
                  vecs[i].ir_load_n, vecs[i].ir_en_n, vecs[i].halt, vecs[i].bus_in);
            #3;
            check($sformatf("v%0d bus_out", i), u_if.bus_out, vecs[i].exp_bus);
            check($sformatf("v%0d bus_oe", i), {7'h0, u_if.bus_oe}, {7'h0, vecs[i].exp_oe});
            @(posedge clk); #1;
            check_state($sformatf("v%0d", i), vecs[i].exp_pc, vecs[i].exp_op,
                        vecs[i].exp_valid, vecs[i].exp_conf);
        end

        // Asynchronous reset mid-cycle while the PC is driving the bus
        drive(1, 1, 0, 1, 1, 0, 8'h00);
        #3;
        check("pre-reset bus_oe", {7'h0, u_if.bus_oe}, 8'h01);
        rst_n = 1'b0;
        #1;
        check("async bus_oe",  {7'h0, u_if.bus_oe}, 8'h00);
        check("async bus_out", u_if.bus_out, 8'h00);
        check_state("async", 4'h0, 4'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_state("held in reset", 4'h0, 4'h0, 1'b0, 1'b0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check_state("first edge after reset", 4'h1, 4'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_state("second edge after reset", 4'h2, 4'h0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
